maxpool2d_seq_ctrl: RTL and testbench

//   Sequencer for 2D max pooling on a channel-major feature-map buffer.

---
 rtl/maxpool2d_seq_ctrl_if.sv | 57 +++++
 rtl/maxpool2d_seq_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_maxpool2d_seq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool2d_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// maxpool2d_seq_ctrl_if
// Bundles the control handshake and both RAM buses of the max-pool sequencer.
//
// Signals
//   start    control -> seq   start request (sampled only while idle)
//   busy     seq -> control   pass in progress
//   done     seq -> control   one-cycle end-of-pass pulse
//   rd_en    seq -> in RAM    read strobe
//   rd_addr  seq -> in RAM    read address
//   rd_data  in RAM -> seq    read data, one cycle after rd_en
//   wr_en    seq -> out RAM   write strobe
//   wr_addr  seq -> out RAM   write address
//   wr_data  seq -> out RAM   pooled maximum
//
// Modports
//   master   the sequencer (it masters both RAM buses)
//   slave    the surrounding system: controller plus RAMs
// ---------------------------------------------------------------------------
interface maxpool2d_seq_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  start,
        input  rd_data,
        output busy,
        output done,
        output rd_en,
        output rd_addr,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output start,
        output rd_data,
        input  busy,
        input  done,
        input  rd_en,
        input  rd_addr,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/maxpool2d_seq_ctrl.sv
// ---------------------------------------------------------------------------
// maxpool2d_seq_ctrl
// Sequencer for 2D max pooling over a channel-major feature-map RAM. A start
// pulse launches one pass: every input pixel is read once, window by window
// (order c, oy, ox, ky, kx), each POOLxPOOL window is folded into a running
// unsigned max, and one pooled word per window is written to the output RAM.
// done pulses for one cycle once the last write has gone out.
//
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous, active-low reset (aborts a pass in progress)
//   bus     maxpool2d_seq_ctrl_if.master: start/busy/done handshake,
//           input RAM read bus and output RAM write bus
// ---------------------------------------------------------------------------
module maxpool2d_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_W       = 4,
    parameter int IN_H       = 4,
    parameter int CHANNELS   = 2,
    parameter int POOL       = 2,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    maxpool2d_seq_ctrl_if.master  bus
);

    localparam logic [ADDR_WIDTH-1:0] L_POOL  = ADDR_WIDTH'(POOL);
    localparam logic [ADDR_WIDTH-1:0] L_INW   = ADDR_WIDTH'(IN_W);
    localparam logic [ADDR_WIDTH-1:0] L_PLANE = ADDR_WIDTH'(IN_W * IN_H);
    localparam logic [ADDR_WIDTH-1:0] L_KMAX  = ADDR_WIDTH'(POOL - 1);
    localparam logic [ADDR_WIDTH-1:0] L_OXMAX = ADDR_WIDTH'(IN_W / POOL - 1);
    localparam logic [ADDR_WIDTH-1:0] L_OYMAX = ADDR_WIDTH'(IN_H / POOL - 1);
    localparam logic [ADDR_WIDTH-1:0] L_CMAX  = ADDR_WIDTH'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic                  r_drainCnt;

    logic [ADDR_WIDTH-1:0] r_kx, r_ky, r_ox, r_oy, r_c;
    logic [ADDR_WIDTH-1:0] w_rdAddr;
    logic                  w_rdEn;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_doneNext;
    logic                  w_firstOfWin;
    logic                  w_lastOfWin;
    logic                  w_lastRead;

    logic                  r_tagValid;
    logic                  r_tagFirst;
    logic                  r_tagLast;
    logic [DATA_WIDTH-1:0] r_max;
    logic [DATA_WIDTH-1:0] w_newMax;

    logic                  r_wrEn;
    logic [ADDR_WIDTH-1:0] r_wrAddr;
    logic [ADDR_WIDTH-1:0] r_wrCnt;
    logic [DATA_WIDTH-1:0] r_wrData;
    logic                  r_done;

    // Window position flags for the read being issued this cycle.
    assign w_firstOfWin = (r_kx == '0) && (r_ky == '0);
    assign w_lastOfWin  = (r_kx == L_KMAX) && (r_ky == L_KMAX);
    assign w_lastRead   = w_lastOfWin && (r_ox == L_OXMAX) && (r_oy == L_OYMAX)
                          && (r_c == L_CMAX);
    assign w_rdAddr     = r_c * L_PLANE + (r_oy * L_POOL + r_ky) * L_INW
                          + r_ox * L_POOL + r_kx;

    // State register; the drain counter gives DRAIN its fixed two-cycle length.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_drainCnt <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_drainCnt <= (r_state == S_DRAIN) && !r_drainCnt;
        end
    end

    // Next-state and per-state outputs. The read strobe is decoded straight
    // from RUN so reads start the cycle after start is accepted.
    always_comb begin
        w_stateNext = r_state;
        w_rdEn      = 1'b0;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        w_doneNext  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_stateNext = S_RUN;
                end
            end
            S_RUN: begin
                w_rdEn = 1'b1;
                w_busy = 1'b1;
                if (w_lastRead) begin
                    w_stateNext = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_drainCnt) begin
                    w_stateNext = S_IDLE;
                    w_doneNext  = 1'b1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Nested read counters, innermost kx. After the last read every counter
    // wraps to zero, so the next pass starts from address 0 without help.
    always_ff @(posedge clk) begin
        if (!rst_n || w_accept) begin
            r_kx <= '0;
            r_ky <= '0;
            r_ox <= '0;
            r_oy <= '0;
            r_c  <= '0;
        end else if (w_rdEn) begin
            if (r_kx != L_KMAX) begin
                r_kx <= r_kx + 1'b1;
            end else begin
                r_kx <= '0;
                if (r_ky != L_KMAX) begin
                    r_ky <= r_ky + 1'b1;
                end else begin
                    r_ky <= '0;
                    if (r_ox != L_OXMAX) begin
                        r_ox <= r_ox + 1'b1;
                    end else begin
                        r_ox <= '0;
                        if (r_oy != L_OYMAX) begin
                            r_oy <= r_oy + 1'b1;
                        end else begin
                            r_oy <= '0;
                            r_c  <= (r_c != L_CMAX) ? r_c + 1'b1 : '0;
                        end
                    end
                end
            end
        end
    end

    // The first element of a window replaces the running max outright, so
    // nothing carries over between windows or passes.
    assign w_newMax = r_tagFirst ? bus.rd_data
                    : ((bus.rd_data > r_max) ? bus.rd_data : r_max);

    // Tags ride one cycle behind the read so they meet rd_data. When the last
    // element of a window folds in, the result goes straight to the write
    // registers; wr_addr/wr_data otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tagValid <= 1'b0;
            r_tagFirst <= 1'b0;
            r_tagLast  <= 1'b0;
            r_max      <= '0;
            r_wrEn     <= 1'b0;
            r_wrAddr   <= '0;
            r_wrCnt    <= '0;
            r_wrData   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_tagValid <= w_rdEn;
            r_tagFirst <= w_rdEn && w_firstOfWin;
            r_tagLast  <= w_rdEn && w_lastOfWin;
            r_wrEn     <= 1'b0;
            r_done     <= w_doneNext;
            if (w_accept) begin
                r_wrCnt <= '0;
            end else if (r_tagValid && r_tagLast) begin
                r_wrCnt <= r_wrCnt + 1'b1;
            end
            if (r_tagValid) begin
                r_max <= w_newMax;
                if (r_tagLast) begin
                    r_wrEn   <= 1'b1;
                    r_wrData <= w_newMax;
                    r_wrAddr <= r_wrCnt;
                end
            end
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = r_done;
    assign bus.rd_en   = w_rdEn;
    assign bus.rd_addr = w_rdAddr;
    assign bus.wr_en   = r_wrEn;
    assign bus.wr_addr = r_wrAddr;
    assign bus.wr_data = r_wrData;

endmodule

// File: tb/tb_maxpool2d_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_maxpool2d_seq_ctrl
// Directed bench for the max-pool sequencer with a behavioural input RAM.
// Stimulus pushes the expected read addresses and writes into queues; an
// independent monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_maxpool2d_seq_ctrl;

    localparam int NREADS  = 32;
    localparam int NWRITES = 8;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    maxpool2d_seq_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    maxpool2d_seq_ctrl #(
        .DATA_WIDTH(8),
        .IN_W(4),
        .IN_H(4),
        .CHANNELS(2),
        .POOL(2),
        .ADDR_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [7:0] mem [0:31];

    // Input RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.rd_data <= 8'd0;
        end else if (bus.rd_en) begin
            bus.rd_data <= mem[bus.rd_addr[4:0]];
        end
    end

    // Hand-listed read order for one 4x4 channel plane.
    int rdOrder [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    int wrRamp  [8]  = '{6, 8, 14, 16, 22, 24, 30, 32};

    logic [7:0] rdQ [$];
    wr_t        wrQ [$];

    int   checks = 0;
    int   errors = 0;
    int   edgeCnt = 0;
    int   acceptEdge = 0;
    int   busyCnt = 0;
    int   doneCnt = 0;
    logic b2bCheck = 1'b0;
    logic prevDone = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edgeCnt++;
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [7:0] expAddr;
        wr_t        expWr;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busyCnt  = 0;
                prevDone = 1'b0;
            end else begin
                if (b2bCheck && prevDone) begin
                    checkOutput("b2bRead", 32'(bus.rd_en), 32'd1);
                end
                if (bus.rd_en) begin
                    if (rdQ.size() == 0) begin
                        checkOutput("unexpectedRead", 32'(bus.rd_addr), 32'hFFFF);
                    end else begin
                        expAddr = rdQ.pop_front();
                        checkOutput("rdAddr", 32'(bus.rd_addr), 32'(expAddr));
                    end
                end
                if (bus.wr_en) begin
                    if (wrQ.size() == 0) begin
                        checkOutput("unexpectedWrite", 32'(bus.wr_addr), 32'hFFFF);
                    end else begin
                        expWr = wrQ.pop_front();
                        checkOutput("wrAddr", 32'(bus.wr_addr), 32'(expWr.addr));
                        checkOutput("wrData", 32'(bus.wr_data), 32'(expWr.data));
                    end
                end
                if (bus.busy) begin
                    busyCnt++;
                end
                if (bus.done) begin
                    doneCnt++;
                    checkOutput("busyCycles", 32'(busyCnt), 32'd34);
                    checkOutput("busyAtDone", 32'(bus.busy), 32'd0);
                    checkOutput("doneCycle", 32'(edgeCnt + 1 - acceptEdge), 32'd35);
                    busyCnt = 0;
                end
                prevDone = bus.done;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fillRamp();
        for (int i = 0; i < 32; i++) mem[i] = 8'(i + 1);
    endtask

    task automatic fillZero();
        for (int i = 0; i < 32; i++) mem[i] = 8'd0;
    endtask

    task automatic pushReads();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 16; i++)
                rdQ.push_back(8'(c * 16 + rdOrder[i]));
    endtask

    task automatic pushWrite(input int a, input int d);
        wr_t w;
        w.addr = 8'(a);
        w.data = 8'(d);
        wrQ.push_back(w);
    endtask

    task automatic pushRamp();
        pushReads();
        for (int i = 0; i < NWRITES; i++) pushWrite(i, wrRamp[i]);
    endtask

    // One-cycle start pulse; the next rising edge is the accept edge.
    task automatic applyStimulus();
        acceptEdge = edgeCnt + 1;
        bus.start  = 1'b1;
        tick(1);
        bus.start  = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) return;
        end
        checkOutput("doneTimeout", 32'd0, 32'd1);
    endtask

    task automatic checkQueues(input string tag);
        checkOutput({tag, "_rdQLeft"}, 32'(rdQ.size()), 32'd0);
        checkOutput({tag, "_wrQLeft"}, 32'(wrQ.size()), 32'd0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_rd_en"},   32'(bus.rd_en),   32'd0);
        checkOutput({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
        checkOutput({tag, "_wr_en"},   32'(bus.wr_en),   32'd0);
        checkOutput({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        checkOutput({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        checkOutput({tag, "_busy"},    32'(bus.busy),    32'd0);
        checkOutput({tag, "_done"},    32'(bus.done),    32'd0);
    endtask

    initial begin
        int d0;
        bus.start = 1'b0;
        fillRamp();
        rst_n = 1'b0;
        tick(3);
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        tick(2);

        $display("[TB] scenario 1: ramp data");
        pushRamp();
        applyStimulus();
        waitDone();
        checkQueues("s1");
        tick(3);

        $display("[TB] scenario 2: max in first window position");
        fillZero();
        mem[0] = 8'd255;
        mem[1] = 8'd3;
        mem[4] = 8'd7;
        mem[5] = 8'd9;
        pushReads();
        pushWrite(0, 255);
        for (int i = 1; i < NWRITES; i++) pushWrite(i, 0);
        applyStimulus();
        waitDone();
        checkQueues("s2");
        tick(3);

        $display("[TB] scenario 3: all-zero RAM");
        fillZero();
        pushReads();
        for (int i = 0; i < NWRITES; i++) pushWrite(i, 0);
        applyStimulus();
        waitDone();
        checkQueues("s3");
        tick(3);

        $display("[TB] scenario 4: start pulse mid-pass");
        fillRamp();
        pushRamp();
        d0 = doneCnt;
        applyStimulus();
        tick(8);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        waitDone();
        tick(20);
        checkOutput("s4_singleDone", 32'(doneCnt - d0), 32'd1);
        checkQueues("s4");

        $display("[TB] scenario 5: reset at cycle 12");
        pushRamp();
        applyStimulus();
        tick(10);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checkIdleOutputs("abort");
        rdQ.delete();
        wrQ.delete();
        d0 = doneCnt;
        tick(40);
        checkOutput("s5_noDone", 32'(doneCnt - d0), 32'd0);
        pushRamp();
        applyStimulus();
        waitDone();
        checkQueues("s5");
        tick(3);

        $display("[TB] scenario 6: start held through done");
        pushRamp();
        pushRamp();
        b2bCheck   = 1'b1;
        acceptEdge = edgeCnt + 1;
        bus.start  = 1'b1;
        waitDone();
        tick(1);
        bus.start  = 1'b0;
        acceptEdge = edgeCnt;
        waitDone();
        b2bCheck   = 1'b0;
        tick(3);
        checkQueues("s6");
        checkOutput("s6_idleAfter", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout actual=%0d expected=0", edgeCnt);
        $fatal(1, "[TB] timeout");
    end

endmodule
